// File: rtl/loader_defs_pkg.sv
// rtl/loader_defs_pkg.sv - shared state encoding and CMD field definitions for mem_loader
//
// Contents:
//   state_t          loader FSM states
//   CMD_TGT_BIT      CMD bit selecting the write target
//   CMD_GO_BIT       CMD bit requesting core release after the packet
//   TGT_DM / TGT_IM  target codes carried from CMD to the write generator
package loader_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int   CMD_TGT_BIT = 0;
    localparam int   CMD_GO_BIT  = 7;

    localparam logic TGT_DM = 1'b0;
    localparam logic TGT_IM = 1'b1;

endpackage

// File: rtl/loader_wr_gen.sv
// rtl/loader_wr_gen.sv - address counter and registered memory write generation
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load the address counter from load_addr
//   load_addr    start address of the packet
//   write        issue one write of byte_in at the current counter next cycle
//   tgt          write target (TGT_DM / TGT_IM)
//   byte_in      payload byte to write
//   dm_we/im_we  one-cycle write strobes, at most one high at a time
//   wr_addr      registered write address, holds between writes
//   wr_data      registered zero-extended write data, holds between writes
module loader_wr_gen
    import loader_defs_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              write,
    input  logic              tgt,
    input  logic [IN_W-1:0]   byte_in,
    output logic              dm_we,
    output logic              im_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic [ADDR_W-1:0] addr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            dm_we    <= 1'b0;
            im_we    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            dm_we <= 1'b0;
            im_we <= 1'b0;
            if (load) begin
                addr_cnt <= load_addr;
            end else if (write) begin
                dm_we    <= (tgt == TGT_DM);
                im_we    <= (tgt == TGT_IM);
                wr_addr  <= addr_cnt;
                wr_data  <= DATA_W'(byte_in);
                // wraps modulo 2^ADDR_W with no indication
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed byte stream to DM/IM write loader with core release control
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte and sticky err)
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   s_data       stream byte, held until accepted
//   s_valid      s_data valid
//   s_ready      byte can be accepted this cycle (low during reset and in FIN)
//   dm_we/im_we  memory write strobes, one cycle per payload byte
//   wr_addr      write address
//   wr_data      payload byte zero-extended
//   core_run     cores released; low holds cores
//   busy         packet in progress
//   err          sticky checksum error (0 without LOADER_CHECKSUM_EN)
module mem_loader
    import loader_defs_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              dm_we,
    output logic              im_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_run,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = IN_W + 1;

    state_t           state, state_next;
    logic             ready_en;
    logic             accept;
    logic             ld_addr, wr_byte;
    logic             tgt_q, go_q;
    logic [CNT_W-1:0] remaining;
    logic             run_ok;

    // ready_en keeps s_ready low while reset is held and until the first edge after release
    assign s_ready = ready_en && (state != ST_FIN);
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_addr    = 1'b0;
        wr_byte    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (accept) begin
                    ld_addr    = 1'b1;
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (accept) begin
                    wr_byte = 1'b1;
                    if (remaining == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_FIN;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_next = ST_FIN;
            end
`endif
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            tgt_q     <= TGT_DM;
            go_q      <= 1'b0;
            remaining <= '0;
            core_run  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (state == ST_IDLE && accept) begin
                tgt_q    <= s_data[CMD_TGT_BIT];
                go_q     <= s_data[CMD_GO_BIT];
                core_run <= 1'b0;
            end
            if (state == ST_LEN && accept) begin
                // a LEN byte of zero encodes a full 2^IN_W byte payload
                remaining <= (s_data == '0) ? (CNT_W'(1) << IN_W) : CNT_W'(s_data);
            end
            if (wr_byte) begin
                remaining <= remaining - 1'b1;
            end
            if (state == ST_FIN) begin
                core_run <= go_q && run_ok;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [IN_W-1:0] csum;
    logic            pkt_bad;
    logic            err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum    <= '0;
            pkt_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept) begin
                csum    <= '0;
                pkt_bad <= 1'b0;
            end
            if (wr_byte) begin
                csum <= csum ^ s_data;
            end
            if (state == ST_CSUM && accept && (s_data != csum)) begin
                pkt_bad <= 1'b1;
                err_q   <= 1'b1;
            end
        end
    end

    assign err    = err_q;
    assign run_ok = !pkt_bad;
`else
    assign err    = 1'b0;
    assign run_ok = 1'b1;
`endif

    loader_wr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IN_W   (IN_W)
    ) u_wr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ld_addr),
        .load_addr (ADDR_W'(s_data)),
        .write     (wr_byte),
        .tgt       (tgt_q),
        .byte_in   (s_data),
        .dm_we     (dm_we),
        .im_we     (im_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

endmodule
